// File: rtl/ysyx_25030081_pkg.sv
// Shared definitions for the writeback stage: load funct3 encodings.
package ysyx_25030081_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/ysyx_25030081_load_ext.sv
// Combinational load extraction: picks the byte/half/word out of an aligned
// memory word and sign- or zero-extends it.
module ysyx_25030081_load_ext
  import ysyx_25030081_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = data[{offset, 3'b000} +: 8];
  assign half_sel = data[{offset[1], 4'b0000} +: 16];

  always_comb begin
    value = data;
    case (funct3)
      LB:      value = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      LBU:     value = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      LH:      value = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      LHU:     value = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      LW:      value = data;
      default: value = data;
    endcase
  end

endmodule

// File: rtl/ysyx_25030081_wbu.sv
// Writeback unit: two-entry skid buffer between execute results and the
// register-file commit port, with a retired-instruction counter.
module ysyx_25030081_wbu
  import ysyx_25030081_pkg::*;
#(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  input  logic [RF_ADDR_WIDTH-1:0] in_rd,
  input  logic                     in_rd_wen,
  input  logic [DATA_WIDTH-1:0]    in_result,
  input  logic                     in_is_load,
  input  logic [2:0]               in_ld_funct3,
  input  logic [1:0]               in_ld_offset,
  input  logic [DATA_WIDTH-1:0]    in_ld_data,

  output logic                     rf_wen,
  output logic [RF_ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,

  output logic                     commit_valid,
  input  logic                     commit_ready,
  output logic [DATA_WIDTH-1:0]    commit_pc,
  output logic [RF_ADDR_WIDTH-1:0] commit_rd,
  output logic [DATA_WIDTH-1:0]    commit_wdata,
  output logic [63:0]              retire_cnt
);

  logic [DATA_WIDTH-1:0]    ld_value;
  logic [DATA_WIDTH-1:0]    in_wdata;

  logic                     head_valid, skid_valid, in_ready_q;
  logic [DATA_WIDTH-1:0]    head_pc, head_wdata, skid_pc, skid_wdata;
  logic [RF_ADDR_WIDTH-1:0] head_rd, skid_rd;
  logic                     head_rd_wen, skid_rd_wen;

  logic                     accept, fire;
  logic                     head_valid_n, skid_valid_n;
  logic                     head_load, head_from_skid, skid_load;

  ysyx_25030081_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
    .funct3 (in_ld_funct3),
    .offset (in_ld_offset),
    .data   (in_ld_data),
    .value  (ld_value)
  );

  assign in_wdata = in_is_load ? ld_value : in_result;
  assign accept   = in_valid & in_ready_q;
  assign fire     = head_valid & commit_ready;

  // skid is only filled when head is occupied and staying, so in_ready low
  // guarantees accept never coincides with a skid->head move
  always_comb begin
    head_valid_n   = head_valid;
    skid_valid_n   = skid_valid;
    head_load      = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (fire) begin
      if (skid_valid) begin
        head_from_skid = 1'b1;
        skid_valid_n   = 1'b0;
      end else if (accept) begin
        head_load = 1'b1;
      end else begin
        head_valid_n = 1'b0;
      end
    end else if (accept) begin
      if (!head_valid) begin
        head_load    = 1'b1;
        head_valid_n = 1'b1;
      end else begin
        skid_load    = 1'b1;
        skid_valid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      retire_cnt <= 64'd0;
    end else begin
      head_valid <= head_valid_n;
      skid_valid <= skid_valid_n;
      in_ready_q <= ~skid_valid_n;
      if (fire) retire_cnt <= retire_cnt + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (head_from_skid) begin
      head_pc     <= skid_pc;
      head_rd     <= skid_rd;
      head_rd_wen <= skid_rd_wen;
      head_wdata  <= skid_wdata;
    end else if (head_load) begin
      head_pc     <= in_pc;
      head_rd     <= in_rd;
      head_rd_wen <= in_rd_wen;
      head_wdata  <= in_wdata;
    end
    if (skid_load) begin
      skid_pc     <= in_pc;
      skid_rd     <= in_rd;
      skid_rd_wen <= in_rd_wen;
      skid_wdata  <= in_wdata;
    end
  end

  assign in_ready     = in_ready_q;
  assign commit_valid = head_valid;
  assign commit_pc    = head_pc;
  assign commit_rd    = head_rd;
  assign commit_wdata = head_wdata;
  assign rf_wen       = fire & head_rd_wen & (head_rd != '0);
  assign rf_waddr     = head_rd;
  assign rf_wdata     = head_wdata;

endmodule

// File: tb/tb_ysyx_25030081_wbu.sv
// Directed bench for the writeback unit: load extraction, backpressure,
// throughput, rd0 suppression and mid-operation reset.
module tb_ysyx_25030081_wbu;

  logic        clk, rst;
  logic        in_valid, in_ready, in_rd_wen, in_is_load;
  logic [31:0] in_pc, in_result, in_ld_data;
  logic [4:0]  in_rd;
  logic [2:0]  in_ld_funct3;
  logic [1:0]  in_ld_offset;
  logic        rf_wen, commit_valid, commit_ready;
  logic [4:0]  rf_waddr, commit_rd;
  logic [31:0] rf_wdata, commit_pc, commit_wdata;
  logic [63:0] retire_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_ret = 0;

  ysyx_25030081_wbu #(.RF_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
    .in_rd_wen(in_rd_wen), .in_result(in_result), .in_is_load(in_is_load),
    .in_ld_funct3(in_ld_funct3), .in_ld_offset(in_ld_offset), .in_ld_data(in_ld_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
    .commit_rd(commit_rd), .commit_wdata(commit_wdata), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                        input logic wen, input logic [31:0] res, input logic isl,
                        input logic [2:0] f3, input logic [1:0] off, input logic [31:0] ld);
    in_valid = v; in_pc = pc; in_rd = rd; in_rd_wen = wen; in_result = res;
    in_is_load = isl; in_ld_funct3 = f3; in_ld_offset = off; in_ld_data = ld;
  endtask

  // one load through an idle pipe with commit_ready high
  task automatic load_case(input string tag, input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] ld, input logic [4:0] rd, input logic [31:0] exp);
    @(negedge clk);
    set_in(1'b1, 32'h1000 + {27'd0, rd}, rd, 1'b1, 32'h5555_5555, 1'b1, f3, off, ld);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk({tag, "_wen"},   {63'd0, rf_wen}, 64'd1);
    chk({tag, "_waddr"}, {59'd0, rf_waddr}, {59'd0, rd});
    chk({tag, "_wdata"}, {32'd0, rf_wdata}, {32'd0, exp});
    exp_ret++;
  endtask

  initial begin
    rst = 1'b1; commit_ready = 1'b0;
    set_in(1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 3'b000, 2'b00, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_cvalid",   {63'd0, commit_valid}, 64'd0);
    chk("rst_retire",   retire_cnt, 64'd0);
    chk("rst_rf_wen",   {63'd0, rf_wen}, 64'd0);

    // load extraction
    commit_ready = 1'b1;
    load_case("lb",     3'b000, 2'd3, 32'h80FF_1234, 5'd5, 32'hFFFF_FF80);
    load_case("lbu",    3'b100, 2'd3, 32'h80FF_1234, 5'd5, 32'h0000_0080);
    load_case("lb0",    3'b000, 2'd0, 32'h80FF_1234, 5'd6, 32'h0000_0034);
    load_case("lh",     3'b001, 2'd2, 32'h8001_7FFF, 5'd7, 32'hFFFF_8001);
    load_case("lhu",    3'b101, 2'd2, 32'h8001_7FFF, 5'd8, 32'h0000_8001);
    load_case("lh_lo",  3'b001, 2'd0, 32'h8001_7FFF, 5'd9, 32'h0000_7FFF);
    load_case("lw",     3'b010, 2'd1, 32'h8001_7FFF, 5'd10, 32'h8001_7FFF);
    load_case("raw011", 3'b011, 2'd2, 32'hA5A5_0F0F, 5'd11, 32'hA5A5_0F0F);

    // rd 0: commits and counts, but never writes
    @(negedge clk);
    chk("load_retire", retire_cnt, exp_ret);
    set_in(1'b1, 32'h2000, 5'd0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3'b000, 2'd0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rd0_cvalid", {63'd0, commit_valid}, 64'd1);
    chk("rd0_wdata",  {32'd0, commit_wdata}, 64'hDEAD_BEEF);
    chk("rd0_rf_wen", {63'd0, rf_wen}, 64'd0);
    exp_ret++;
    @(negedge clk);
    #1;
    chk("rd0_retire", retire_cnt, exp_ret);
    chk("rd0_rf_wen2", {63'd0, rf_wen}, 64'd0);

    // backpressure: A, B, C back-to-back with commit_ready low
    commit_ready = 1'b0;
    set_in(1'b1, 32'h3000, 5'd1, 1'b1, 32'hAAAA_0001, 1'b0, 3'b000, 2'd0, 32'h0);
    @(negedge clk);
    #1;
    chk("bp_ready1", {63'd0, in_ready}, 64'd1);
    set_in(1'b1, 32'h3004, 5'd2, 1'b1, 32'hBBBB_0002, 1'b0, 3'b000, 2'd0, 32'h0);
    @(negedge clk);
    #1;
    chk("bp_ready2", {63'd0, in_ready}, 64'd0);
    chk("bp_pc2",    {32'd0, commit_pc}, 64'h3000);
    chk("bp_wen2",   {63'd0, rf_wen}, 64'd0);
    set_in(1'b1, 32'h3008, 5'd3, 1'b1, 32'hCCCC_0003, 1'b0, 3'b000, 2'd0, 32'h0);
    @(negedge clk);
    #1;
    chk("bp_ready3", {63'd0, in_ready}, 64'd0);
    chk("bp_pc3",    {32'd0, commit_pc}, 64'h3000);
    chk("bp_wdata3", {32'd0, commit_wdata}, 64'hAAAA_0001);
    chk("bp_wen3",   {63'd0, rf_wen}, 64'd0);
    commit_ready = 1'b1;
    #1;
    chk("bp_A_wen",   {63'd0, rf_wen}, 64'd1);
    chk("bp_A_waddr", {59'd0, rf_waddr}, 64'd1);
    @(negedge clk);
    #1;
    chk("bp_B_pc",    {32'd0, commit_pc}, 64'h3004);
    chk("bp_B_wdata", {32'd0, rf_wdata}, 64'hBBBB_0002);
    chk("bp_B_wen",   {63'd0, rf_wen}, 64'd1);
    chk("bp_B_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_C_pc",    {32'd0, commit_pc}, 64'h3008);
    chk("bp_C_waddr", {59'd0, rf_waddr}, 64'd3);
    chk("bp_C_wen",   {63'd0, rf_wen}, 64'd1);
    exp_ret += 3;
    @(negedge clk);
    #1;
    chk("bp_empty",  {63'd0, commit_valid}, 64'd0);
    chk("bp_retire", retire_cnt, exp_ret);

    // throughput: 10 back-to-back from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10)
        set_in(1'b1, 32'h4000 + 32'(i * 4), 5'(i + 1), 1'b1, 32'h0100_0000 + 32'(i),
               1'b0, 3'b000, 2'd0, 32'h0);
      else
        in_valid = 1'b0;
      #1;
      if (i > 0) begin
        chk($sformatf("tp_wen%0d", i),   {63'd0, rf_wen}, 64'd1);
        chk($sformatf("tp_wdata%0d", i), {32'd0, rf_wdata}, {32'd0, 32'h0100_0000 + 32'(i - 1)});
        chk($sformatf("tp_ready%0d", i), {63'd0, in_ready}, 64'd1);
      end
      @(negedge clk);
    end
    #1;
    chk("tp_empty",  {63'd0, commit_valid}, 64'd0);
    chk("tp_retire", retire_cnt, 64'd10);

    // reset with two buffered entries
    commit_ready = 1'b0;
    set_in(1'b1, 32'h5000, 5'd4, 1'b1, 32'h1111_1111, 1'b0, 3'b000, 2'd0, 32'h0);
    @(negedge clk);
    set_in(1'b1, 32'h5004, 5'd5, 1'b1, 32'h2222_2222, 1'b0, 3'b000, 2'd0, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_full", {63'd0, in_ready}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    commit_ready = 1'b1;
    #1;
    chk("mr_cvalid", {63'd0, commit_valid}, 64'd0);
    chk("mr_rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("mr_retire", retire_cnt, 64'd0);
    chk("mr_ready",  {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    #1;
    chk("mr_rf_wen2", {63'd0, rf_wen}, 64'd0);
    chk("mr_retire2", retire_cnt, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_wbu.md
YSYX_25030081_WBU -- requirements
Module: ysyx_25030081_wbu

Interface
REQ-001 SHALL have parameter RF_ADDR_WIDTH, default 5, register-file address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 SHALL have these upstream ports: in_valid input 1 (result offered); in_ready output 1 (result accepted when in_valid & in_ready); in_pc input DATA_WIDTH (instruction PC); in_rd input RF_ADDR_WIDTH (destination register); in_rd_wen input 1 (instruction writes rd); in_result input DATA_WIDTH (ALU/CSR result); in_is_load input 1 (use load data); in_ld_funct3 input 3 (load type); in_ld_offset input 2 (address[1:0]); in_ld_data input DATA_WIDTH (raw aligned memory word).
REQ-005 SHALL have these register-file ports: rf_wen output 1; rf_waddr output RF_ADDR_WIDTH; rf_wdata output DATA_WIDTH.
REQ-006 SHALL have these commit/trace ports: commit_valid output 1; commit_ready input 1; commit_pc output DATA_WIDTH; commit_rd output RF_ADDR_WIDTH; commit_wdata output DATA_WIDTH; retire_cnt output 64 (retired-instruction count).

Function
REQ-007 SHALL compute the writeback value at input: in_result if !in_is_load, else load-extracted in_ld_data.
REQ-008 Load extraction SHALL be: 000 lb = sign-extended byte at in_ld_offset; 100 lbu = zero-extended byte; 001 lh = sign-extended half at in_ld_offset[1]; 101 lhu = zero-extended half; 010 lw = full word, offset ignored; 011/110/111 = raw in_ld_data.
REQ-009 SHALL buffer entries in a 2-entry skid structure: main register (head) plus one skid register.
REQ-010 in_ready SHALL be registered and equal !skid_valid.
REQ-011 An accepted entry SHALL go to head if head is empty or leaving this cycle, else to skid; on head departure a valid skid entry SHALL move to head in the same edge.
REQ-012 commit_valid SHALL equal head_valid; commit_pc/commit_rd/commit_wdata SHALL reflect head fields and hold stable while commit_valid & !commit_ready.
REQ-013 Commit fire = commit_valid & commit_ready; the rf write SHALL occur only in the fire cycle: rf_wen = fire & head_rd_wen & (head_rd != 0).
REQ-014 rf_waddr/rf_wdata SHALL equal head rd/wdata combinationally (write lands at the next clk edge in the register file).
REQ-015 Writes to rd 0 SHALL never assert rf_wen; commit SHALL still fire and count.
REQ-016 retire_cnt SHALL increment by 1 per fire and wrap from 2^64-1 to 0.
REQ-017 Simultaneous accept and fire with both entries valid SHALL not occur (in_ready low); accept and fire with one entry SHALL keep throughput of 1 per cycle.
REQ-018 Entries SHALL commit strictly in acceptance order; none dropped or duplicated.

Reset
REQ-019 While rst is high at a clk edge: head_valid = 0, skid_valid = 0, in_ready = 1 after the edge, retire_cnt = 0.
REQ-020 Reset mid-operation SHALL discard buffered entries without any rf_wen; rf_wen and commit_valid SHALL be 0 in the cycle after reset.
REQ-021 Payload registers SHALL NOT require reset.

Structure
REQ-022 Load funct3 encodings (LB, LH, LW, LBU, LHU) SHALL be localparams in shared package ysyx_25030081_pkg.
REQ-023 Load extraction SHALL be a combinational sub-module ysyx_25030081_load_ext (funct3, offset, data -> value).

Verification
REQ-024 lb, offset 3, ld_data 0x80FF_1234, rd 5 -> rf_wen, waddr 5, wdata 0xFFFF_FF80; lbu same -> 0x0000_0080.
REQ-025 lh, offset 2, ld_data 0x8001_7FFF -> 0xFFFF_8001; lhu -> 0x0000_8001; lw, offset 1 -> 0x8001_7FFF.
REQ-026 commit_ready low 3 cycles with 3 back-to-back inputs -> in_ready drops after 2 accepted, outputs stable, no rf_wen; release -> 2 commits in order, then the third accepted.
REQ-027 Continuous in_valid and commit_ready for 10 results -> 10 commits on consecutive cycles, retire_cnt = 10.
REQ-028 rd 0 with in_rd_wen = 1, result 0xDEAD_BEEF -> commit fires, retire_cnt +1, rf_wen never high.
REQ-029 Assert rst with 2 buffered entries -> no rf_wen, commit_valid = 0, retire_cnt = 0, in_ready = 1 next cycle.
